edvs_spinn_pkt_assembler: RTL and testbench

- Converts the eDVS serial byte stream (E0 two-byte address-event format) from the UART receiver into 40-bit SpiNNaker multicast packets.
- Buffers the packets and presents them to the SpiNNaker link driver over a valid/ready packet interface.
- Sits between the UART receiver byte output and the spinn_driver PKT_DATA_IN/PKT_VLD_IN/PKT_RDY_OUT port.

---
 rtl/edvs_spinn_pkt_assembler_if.sv | 19 +
 rtl/edvs_spinn_pkt_assembler.sv | 161 ++++++++++++++++
 tb/tb_edvs_spinn_pkt_assembler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/edvs_spinn_pkt_assembler_if.sv
// Byte-in / packet-out bus of the eDVS-to-SpiNNaker packet assembler.
// The slave modport is the assembler side; master is the UART/driver side.
interface edvs_spinn_pkt_assembler_if;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VLD_IN;
  logic [39:0] PKT_DATA_OUT;
  logic        PKT_VLD_OUT;
  logic        PKT_RDY_IN;

  modport master (
    output BYTE_IN, BYTE_VLD_IN, PKT_RDY_IN,
    input  PKT_DATA_OUT, PKT_VLD_OUT
  );

  modport slave (
    input  BYTE_IN, BYTE_VLD_IN, PKT_RDY_IN,
    output PKT_DATA_OUT, PKT_VLD_OUT
  );
endinterface

// File: rtl/edvs_spinn_pkt_assembler.sv
// eDVS E0 byte pairs -> 40-bit SpiNNaker multicast packets, queued behind a
// registered-output FIFO. Define EDVS_PKT_TIMEOUT_EN for the inter-byte timeout.
module edvs_spinn_pkt_assembler #(
  parameter logic [15:0] VIRTUAL_KEY    = 16'h0200,
  parameter int          FIFO_AW        = 2,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic                        CLK_IN,
  input  logic                        RESET_IN,
  input  logic                        ENABLE_IN,
  edvs_spinn_pkt_assembler_if.slave   bus,
  output logic [15:0]                 DROP_CNT_OUT,
  output logic [15:0]                 SYNC_ERR_CNT_OUT
);

  localparam logic [0:0] WAIT_HI = 1'b0;
  localparam logic [0:0] WAIT_LO = 1'b1;
  localparam int         DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  // ---------------- parser ----------------
  logic [0:0]  state_q, state_d;
  logic [6:0]  y_q, y_d;
  logic        pv_q, pv_d;
  logic [39:0] pd_q, pd_d;
  logic        sync_inc;
  logic [31:0] key;

  assign key = {VIRTUAL_KEY, 1'b0, bus.BYTE_IN[7], y_q, bus.BYTE_IN[6:0]};

`ifdef EDVS_PKT_TIMEOUT_EN
  logic [31:0] tmr_q, tmr_d;
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    pv_d     = 1'b0;
    pd_d     = pd_q;
    sync_inc = 1'b0;
`ifdef EDVS_PKT_TIMEOUT_EN
    tmr_d    = 32'd0;
`endif
    if (!ENABLE_IN) begin
      state_d = WAIT_HI;
    end else if (bus.BYTE_VLD_IN) begin
      if (state_q == WAIT_HI) begin
        if (bus.BYTE_IN[7]) begin
          y_d     = bus.BYTE_IN[6:0];
          state_d = WAIT_LO;
        end else begin
          sync_inc = 1'b1;
        end
      end else begin
        // Odd parity over the whole 40-bit word lives in header[0].
        pd_d    = {key, 7'd0, ~^key};
        pv_d    = 1'b1;
        state_d = WAIT_HI;
      end
    end
`ifdef EDVS_PKT_TIMEOUT_EN
    else if (state_q == WAIT_LO) begin
      if (tmr_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d  = WAIT_HI;
        sync_inc = 1'b1;
      end else begin
        tmr_d = tmr_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q <= WAIT_HI;
      y_q     <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
`ifdef EDVS_PKT_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
`ifdef EDVS_PKT_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end

  // ---------------- FIFO with output register ----------------
  logic [39:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] rd_q, wr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic [39:0]        out_q;
  logic               ov_q;

  logic xfer, full, accept, drop, load_out, pop, bypass, wr_en;

  assign xfer     = ov_q & bus.PKT_RDY_IN;
  assign full     = ov_q & (cnt_q == DEPTH_C);
  assign accept   = pv_q & (~full | xfer);
  assign drop     = pv_q & ~accept;
  assign load_out = ~ov_q | xfer;
  assign pop      = load_out & (cnt_q != '0);
  // An empty queue feeds the push straight into the output register.
  assign bypass   = load_out & (cnt_q == '0) & accept;
  assign wr_en    = accept & ~bypass;

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      if (pop) begin
        out_q <= mem_q[rd_q];
        ov_q  <= 1'b1;
        rd_q  <= rd_q + FIFO_AW'(1);
      end else if (bypass) begin
        out_q <= pd_q;
        ov_q  <= 1'b1;
      end else if (load_out) begin
        ov_q  <= 1'b0;
      end
      if (wr_en) wr_q <= wr_q + FIFO_AW'(1);
      cnt_q <= cnt_q + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop);
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (wr_en) mem_q[wr_q] <= pd_q;
  end

  assign bus.PKT_DATA_OUT = out_q;
  assign bus.PKT_VLD_OUT  = ov_q;

  // ---------------- saturating counters ----------------
  logic [15:0] drop_q, sync_q;

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      drop_q <= '0;
      sync_q <= '0;
    end else begin
      if (drop && drop_q != 16'hFFFF)     drop_q <= drop_q + 16'd1;
      if (sync_inc && sync_q != 16'hFFFF) sync_q <= sync_q + 16'd1;
    end
  end

  assign DROP_CNT_OUT     = drop_q;
  assign SYNC_ERR_CNT_OUT = sync_q;

endmodule

// File: tb/tb_edvs_spinn_pkt_assembler.sv
// Random + directed bench for edvs_spinn_pkt_assembler against a queue-based
// reference model (packet queue of capacity 2**AW + 1, one-cycle push stage).
module tb_edvs_spinn_pkt_assembler;
  localparam logic [15:0] VK  = 16'h0200;
  localparam int          AW  = 2;
  localparam int          CAP = (1 << AW) + 1;
  localparam int          TO  = 10;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] drop, sync;

  edvs_spinn_pkt_assembler_if bus();

  edvs_spinn_pkt_assembler #(
    .VIRTUAL_KEY(VK), .FIFO_AW(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_IN(clk), .RESET_IN(rst), .ENABLE_IN(en), .bus(bus),
    .DROP_CNT_OUT(drop), .SYNC_ERR_CNT_OUT(sync)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(string tag, logic [39:0] got, logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [39:0] mq[$];
  logic [39:0] popped[$];
  bit          hi_v, pend_v;
  logic [6:0]  hi_y;
  logic [39:0] pend;
  int          idle;
  logic [15:0] m_drop, m_sync;

  function automatic logic [39:0] mk(logic [6:0] y, logic p, logic [6:0] x);
    logic [31:0] k;
    k = {VK, 1'b0, p, y, x};
    return {k, 7'd0, ~^k};
  endfunction

  task automatic cyc(bit r, bit e, bit v, logic [7:0] b, bit rdy);
    rst = r; en = e; bus.BYTE_VLD_IN = v; bus.BYTE_IN = b; bus.PKT_RDY_IN = rdy;
    if (r) begin
      mq.delete(); hi_v = 0; pend_v = 0; idle = 0; m_drop = 0; m_sync = 0;
    end else begin
      if (mq.size() > 0 && rdy) popped.push_back(mq.pop_front());
      if (pend_v) begin
        if (mq.size() < CAP) mq.push_back(pend);
        else if (m_drop != 16'hFFFF) m_drop++;
      end
      pend_v = 0;
      if (!e) begin
        hi_v = 0; idle = 0;
      end else if (v) begin
        idle = 0;
        if (!hi_v) begin
          if (b[7]) begin hi_v = 1; hi_y = b[6:0]; end
          else if (m_sync != 16'hFFFF) m_sync++;
        end else begin
          pend = mk(hi_y, b[7], b[6:0]); pend_v = 1; hi_v = 0;
        end
      end else if (hi_v) begin
`ifdef EDVS_PKT_TIMEOUT_EN
        idle++;
        if (idle == TO) begin
          hi_v = 0; idle = 0;
          if (m_sync != 16'hFFFF) m_sync++;
        end
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("vld", 40'(bus.PKT_VLD_OUT), 40'(mq.size() > 0));
    if (mq.size() > 0) chk("data", bus.PKT_DATA_OUT, mq[0]);
    chk("drop_cnt", 40'(drop), 40'(m_drop));
    chk("sync_cnt", 40'(sync), 40'(m_sync));
  endtask

  task automatic idle_n(int n, bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 8'h00, rdy);
  endtask

  task automatic evt(logic [7:0] hi, logic [7:0] lo, bit rdy);
    cyc(0, 1, 1, hi, rdy);
    cyc(0, 1, 1, lo, rdy);
  endtask

  logic [39:0] exp5[$];

  initial begin
    rst = 1; en = 1; bus.BYTE_VLD_IN = 0; bus.BYTE_IN = '0; bus.PKT_RDY_IN = 0;
    cyc(1, 1, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'h00, 0);
    chk("reset_data", bus.PKT_DATA_OUT, 40'd0);

    // single event, latency and exact packet value
    popped.delete();
    evt(8'h85, 8'hA3, 1);
    chk("lat1_vld", 40'(bus.PKT_VLD_OUT), 40'd0);
    idle_n(1, 1);
    chk("lat2_vld", 40'(bus.PKT_VLD_OUT), 40'd1);
    chk("pkt_85a3", bus.PKT_DATA_OUT, 40'h020042A300);
    idle_n(3, 1);
    chk("one_pkt", 40'(popped.size()), 40'd1);

    // two bytes without sync bit
    cyc(1, 1, 0, 8'h00, 1);
    popped.delete();
    cyc(0, 1, 1, 8'h12, 1);
    chk("sync_first", 40'(sync), 40'd1);
    cyc(0, 1, 1, 8'h34, 1);
    idle_n(3, 1);
    chk("sync_two", 40'(sync), 40'd2);
    chk("no_pkt_sync", 40'(popped.size()), 40'd0);

    // overflow: 7 events stalled, then drain in order
    cyc(1, 1, 0, 8'h00, 0);
    exp5.delete();
    for (int i = 0; i < 7; i++) begin
      logic [7:0] h, l;
      h = 8'h80 | 8'(i + 1); l = 8'(8'h10 + i);
      if (i < 5) exp5.push_back(mk(h[6:0], l[7], l[6:0]));
      evt(h, l, 0);
    end
    idle_n(3, 0);
    chk("drop_two", 40'(drop), 40'd2);
    popped.delete();
    idle_n(5, 1);
    chk("drain_cnt", 40'(popped.size()), 40'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++) chk("drain_order", popped[i], exp5[i]);
    chk("drain_empty", 40'(bus.PKT_VLD_OUT), 40'd0);

    // push into full queue while a transfer happens
    cyc(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) evt(8'hC0 | 8'(i), 8'h55, 0);
    idle_n(2, 0);
    cyc(0, 1, 1, 8'hFF, 0);
    cyc(0, 1, 1, 8'h7E, 0);
    cyc(0, 1, 0, 8'h00, 1);
    chk("full_xfer_nodrop", 40'(drop), 40'd0);
    idle_n(7, 1);

    // enable drop discards latched y
    cyc(1, 1, 0, 8'h00, 1);
    popped.delete();
    cyc(0, 1, 1, 8'h81, 1);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 1, 1, 8'h05, 1);
    idle_n(3, 1);
    chk("en_sync", 40'(sync), 40'd1);
    chk("en_no_pkt", 40'(popped.size()), 40'd0);

    // reset with packets queued
    for (int i = 0; i < 3; i++) evt(8'h90, 8'(i), 0);
    idle_n(2, 0);
    cyc(1, 1, 0, 8'h00, 0);
    chk("rst_vld", 40'(bus.PKT_VLD_OUT), 40'd0);
    chk("rst_drop", 40'(drop), 40'd0);
    chk("rst_sync", 40'(sync), 40'd0);

    // inter-byte gap longer than the timeout
    popped.delete();
    cyc(0, 1, 1, 8'h81, 1);
    idle_n(12, 1);
    cyc(0, 1, 1, 8'h05, 1);
    idle_n(3, 1);
`ifdef EDVS_PKT_TIMEOUT_EN
    chk("tmo_sync", 40'(sync), 40'd2);
    chk("tmo_no_pkt", 40'(popped.size()), 40'd0);
`else
    chk("gap_sync", 40'(sync), 40'd0);
    chk("gap_pkt", 40'(popped.size()), 40'd1);
`endif

    // short gap always completes the event
    cyc(1, 1, 0, 8'h00, 1);
    popped.delete();
    cyc(0, 1, 1, 8'h81, 1);
    idle_n(5, 1);
    cyc(0, 1, 1, 8'h05, 1);
    idle_n(3, 1);
    chk("short_sync", 40'(sync), 40'd0);
    chk("short_pkt_cnt", 40'(popped.size()), 40'd1);
    if (popped.size() > 0) chk("short_pkt", popped[0], mk(7'h01, 1'b0, 7'h05));

    // randomized traffic
    cyc(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(499) == 0), ($urandom_range(15) != 0),
          $urandom_range(1), 8'($urandom), $urandom_range(1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
